fizz_buzz_stream: RTL

//  Parametrised, multi-channel FizzBuzz sequence generator. Emits numbers 1..MAX_COUNT
//  as a valid/ready token stream, one token per accepted handshake.

---
 rtl/fizz_buzz_pkg.sv | 16 +
 rtl/fb_residue_counter.sv | 51 +++++
 rtl/fizz_buzz_stream.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fizz_buzz_pkg.sv
// -----------------------------------------------------------------------------
// fizz_buzz_pkg
//   Shared types and defaults for the fizz_buzz_stream generator.
//   fb_state_e   : sequencer state (idle / running a sequence)
//   FB_DIV_W_DEF : default divisor width per channel
// -----------------------------------------------------------------------------
package fizz_buzz_pkg;

   typedef enum logic {
      FB_IDLE = 1'b0,
      FB_RUN  = 1'b1
   } fb_state_e;

   localparam int FB_DIV_W_DEF = 8;

endpackage : fizz_buzz_pkg

// File: rtl/fb_residue_counter.sv
// -----------------------------------------------------------------------------
// fb_residue_counter
//   Tracks (current number mod div) for one channel without a divider.
//   The residue is loaded for number 1 on init and steps once per accepted
//   token on adv, wrapping to zero when it reaches div-1.
// Ports
//   clk, resetn : clock, asynchronous active-low reset
//   div         : channel divisor, 0 = channel disabled
//   init        : load the residue of number 1
//   adv         : advance to the next number
//   residue     : current residue
//   hit         : channel enabled and residue is zero
// -----------------------------------------------------------------------------
module fb_residue_counter
   import fizz_buzz_pkg::*;
#(
   parameter int DIV_W = FB_DIV_W_DEF
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [DIV_W-1:0] div,
   input  logic             init,
   input  logic             adv,
   output logic [DIV_W-1:0] residue,
   output logic             hit
);

   localparam logic [DIV_W-1:0] RES_ONE = DIV_W'(1);

   logic [DIV_W-1:0] res_q;
   logic [DIV_W-1:0] res_last;

   // With div == 0 this wraps at the all-ones value; harmless because the
   // hit output is masked for a disabled channel.
   assign res_last = div - RES_ONE;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         res_q <= '0;
      end else if (init) begin
         // 1 mod 1 is 0; for every other divisor 1 mod div is 1
         res_q <= (div == RES_ONE) ? '0 : RES_ONE;
      end else if (adv) begin
         res_q <= (res_q == res_last) ? '0 : res_q + RES_ONE;
      end
   end

   assign residue = res_q;
   assign hit     = (div != '0) && (res_q == '0);

endmodule : fb_residue_counter

// File: rtl/fizz_buzz_stream.sv
// -----------------------------------------------------------------------------
// fizz_buzz_stream
//   Multi-channel FizzBuzz token generator. Emits 1..MAX_COUNT as a
//   valid/ready stream; each token carries one hit flag per divisor channel.
// Ports
//   clk, resetn        : clock, asynchronous active-low reset
//   start, abort       : begin a sequence (idle only) / return to idle
//   wrap_en            : restart at 1 after MAX_COUNT instead of stopping
//   cfg_we/ch/div      : divisor write port, honoured only while idle
//   out_valid/out_ready: token handshake
//   out_num            : token number
//   out_hit            : per-channel divisibility flags
//   out_all/out_none   : every enabled channel hits / no channel hits
//   busy               : sequence in progress
//   done               : one-cycle pulse after the final token (no wrap)
//
// Handshake: a token transfers on a rising edge where out_valid && out_ready.
// out_valid is high exactly while running; while out_valid && !out_ready all
// out_* hold. Every out_* is a register or a decode of registers, so neither
// out_ready nor start reaches an output combinationally.
// -----------------------------------------------------------------------------
module fizz_buzz_stream
   import fizz_buzz_pkg::*;
#(
   parameter int                      N_CH      = 2,
   parameter int                      CNT_W     = 16,
   parameter int                      DIV_W     = FB_DIV_W_DEF,
   parameter int                      MAX_COUNT = 100,
   parameter logic [N_CH*DIV_W-1:0]   DEF_DIV   = {8'd5, 8'd3}
) (
   input  logic                                        clk,
   input  logic                                        resetn,
   input  logic                                        start,
   input  logic                                        abort,
   input  logic                                        wrap_en,
   input  logic                                        cfg_we,
   input  logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0]  cfg_ch,
   input  logic [DIV_W-1:0]                            cfg_div,
   output logic                                        out_valid,
   input  logic                                        out_ready,
   output logic [CNT_W-1:0]                            out_num,
   output logic [N_CH-1:0]                             out_hit,
   output logic                                        out_all,
   output logic                                        out_none,
   output logic                                        busy,
   output logic                                        done
);

   localparam int               CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [CNT_W-1:0] NUM_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] NUM_MAX = CNT_W'(MAX_COUNT);

   if (N_CH < 1 || MAX_COUNT < 1 ||
       longint'(MAX_COUNT) > ((longint'(1) << CNT_W) - 1)) begin : g_bad_param
      $error("fizz_buzz_stream: bad N_CH/MAX_COUNT/CNT_W combination");
   end

   fb_state_e        state_q, state_d;
   logic [CNT_W-1:0] num_q, num_d;
   logic             done_q, done_d;
   logic             res_init, res_adv;
   logic             start_go;
   logic             accept;

   logic [DIV_W-1:0] div_q [N_CH];
   logic [DIV_W-1:0] res   [N_CH];
   logic [N_CH-1:0]  hit;
   logic [N_CH-1:0]  ch_en;

   assign out_valid = (state_q == FB_RUN);
   assign busy      = (state_q == FB_RUN);
   assign accept    = out_valid && out_ready;
   assign start_go  = (state_q == FB_IDLE) && start && !abort;

   // ---------------------------------------------------------------- divisors
   // A write in the same cycle a sequence starts is dropped so the residues
   // are initialised against the divisors that the whole run will use.
   // An index >= N_CH matches no entry and is therefore ignored.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < N_CH; i++) div_q[i] <= DEF_DIV[i*DIV_W +: DIV_W];
      end else if (cfg_we && (state_q == FB_IDLE) && !start_go) begin
         for (int i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) div_q[i] <= cfg_div;
         end
      end
   end

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= FB_IDLE;
         num_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         num_q   <= num_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      num_d    = num_q;
      done_d   = 1'b0;
      res_init = 1'b0;
      res_adv  = 1'b0;
      case (state_q)
         FB_IDLE: begin
            if (start_go) begin
               state_d  = FB_RUN;
               num_d    = NUM_ONE;
               res_init = 1'b1;
            end
         end
         FB_RUN: begin
            if (abort) begin
               state_d = FB_IDLE;
            end else if (accept) begin
               if (num_q == NUM_MAX) begin
                  if (wrap_en) begin
                     num_d    = NUM_ONE;
                     res_init = 1'b1;
                  end else begin
                     state_d = FB_IDLE;
                     done_d  = 1'b1;
                  end
               end else begin
                  num_d   = num_q + NUM_ONE;
                  res_adv = 1'b1;
               end
            end
         end
         default: state_d = FB_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- channels
   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      fb_residue_counter #(.DIV_W(DIV_W)) u_res (
         .clk     (clk),
         .resetn  (resetn),
         .div     (div_q[g]),
         .init    (res_init),
         .adv     (res_adv),
         .residue (res[g]),
         .hit     (hit[g])
      );
      assign ch_en[g] = (div_q[g] != '0);
   end

   // out_all: at least one channel enabled and every enabled channel sits at
   // residue zero.
   always_comb begin
      out_all = |ch_en;
      for (int i = 0; i < N_CH; i++) begin
         if (ch_en[i] && (res[i] != '0)) out_all = 1'b0;
      end
   end

   assign out_num  = num_q;
   assign out_hit  = hit;
   assign out_none = ~|hit;
   assign done     = done_q;

endmodule : fizz_buzz_stream
